// File: rtl/thermo_mask_stream_pkg.sv
// thermo_mask_stream_pkg: shared defaults and mode encoding for the thermometer-mask stream.
package thermo_mask_stream_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_NUM_CHUNKS = 4;

    typedef enum logic {
        INCL = 1'b0,
        EXCL = 1'b1
    } thermo_mode_e;

endpackage

// File: rtl/thermo_mask_stream_chunk_prefix_or.sv
// chunk_prefix_or: per-chunk MSB-down prefix OR producing the thermometer mask and highest-one position.
module chunk_prefix_or
    import thermo_mask_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int POS_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] chunk,
    input  logic              carry_in,
    input  thermo_mode_e      excl,
    output logic [DATA_W-1:0] mask,
    output logic              any,
    output logic [POS_W-1:0]  hi_pos
);

    logic [DATA_W-1:0] w_pre;
    logic              w_acc;

    always_comb begin
        w_pre  = '0;
        w_acc  = 1'b0;
        hi_pos = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_acc    = w_acc | chunk[i];
            w_pre[i] = w_acc;
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (chunk[i]) hi_pos = POS_W'(i);
        end
    end

    // exclusive mode shifts the prefix down one bit so the first one itself stays clear
    assign any  = w_pre[0];
    assign mask = (excl == EXCL) ? ({1'b0, w_pre[DATA_W-1:1]} | {DATA_W{carry_in}})
                                 : (w_pre | {DATA_W{carry_in}});

endmodule

// File: rtl/thermo_mask_stream.sv
// thermo_mask_stream: streams a chunked frame, emitting thermometer masks below the frame's first one.
module thermo_mask_stream
    import thermo_mask_stream_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
    parameter int IDX_W      = $clog2(DATA_W * NUM_CHUNKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_excl,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_found,
    output logic [IDX_W-1:0]  m_first_idx
);

    localparam int               CNT_W   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int               POS_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_CHUNKS - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_seen;
    thermo_mode_e      r_excl_q;
    logic [IDX_W-1:0]  r_idx;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_last;

    logic              w_first;
    logic              w_carry;
    thermo_mode_e      w_mode;
    logic              w_in_xfer;
    logic              w_any;
    logic              w_hit;
    logic [DATA_W-1:0] w_mask;
    logic [POS_W-1:0]  w_hi_pos;
    logic [IDX_W-1:0]  w_base;
    logic [IDX_W-1:0]  w_idx_nxt;

    chunk_prefix_or #(
        .DATA_W (DATA_W),
        .POS_W  (POS_W)
    ) u_kernel (
        .chunk    (s_data),
        .carry_in (w_carry),
        .excl     (w_mode),
        .mask     (w_mask),
        .any      (w_any),
        .hi_pos   (w_hi_pos)
    );

    // chunk 0 starts a fresh frame: no carry, mode taken live from the input
    assign w_first   = (r_cnt == '0);
    assign w_carry   = w_first ? 1'b0 : r_seen;
    assign w_mode    = w_first ? thermo_mode_e'(s_excl) : r_excl_q;
    assign s_ready   = rst_n & (~r_m_valid | m_ready);
    assign w_in_xfer = s_valid & s_ready;
    assign w_hit     = w_any & ~w_carry;
    assign w_base    = IDX_W'((NUM_CHUNKS - 1 - int'(r_cnt)) * DATA_W);
    assign w_idx_nxt = w_hit ? (w_base + IDX_W'(w_hi_pos)) : (w_first ? '0 : r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_excl_q  <= INCL;
            r_idx     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_cnt    <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
                r_seen   <= w_carry | w_any;
                r_excl_q <= w_mode;
                r_idx    <= w_idx_nxt;
                r_m_data <= w_mask;
                r_m_last <= (r_cnt == CNT_MAX);
            end
            r_m_valid <= w_in_xfer | (r_m_valid & ~m_ready);
        end
    end

    // seen doubles as the found flag: both clear at frame start and set on the first one
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_last      = r_m_last;
    assign m_found     = r_seen;
    assign m_first_idx = r_idx;

endmodule

// File: tb/tb_thermo_mask_stream.sv
// tb_thermo_mask_stream: directed and randomized checks of thermo_mask_stream against a whole-frame model.
module tb_thermo_mask_stream;

    typedef logic [7:0] frame_t [4];
    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       found;
        logic [4:0] idx;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_excl = 1'b0;
    logic [7:0] s_data = '0;
    logic       m_ready = 1'b1;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_found;
    logic [4:0] m_first_idx;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t got_q[$];
    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;

    always #5 clk = ~clk;

    thermo_mask_stream #(
        .DATA_W     (8),
        .NUM_CHUNKS (4),
        .IDX_W      (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_excl      (s_excl),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_found     (m_found),
        .m_first_idx (m_first_idx)
    );

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && m_valid && m_ready)
            got_q.push_back('{m_data, m_last, m_found, m_first_idx});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic f, input logic [4:0] ix);
        exp_q.push_back('{a, 1'b0, f, ix});
        exp_q.push_back('{b, 1'b0, f, ix});
        exp_q.push_back('{c, 1'b0, f, ix});
        exp_q.push_back('{d, 1'b1, f, ix});
    endtask

    // whole-frame view: locate the global first one, then set every bit at/below (or below) it
    task automatic model_frame(input frame_t fr, input bit excl);
        logic [31:0] v;
        logic [31:0] m;
        int p;
        v = {fr[0], fr[1], fr[2], fr[3]};
        p = -1;
        for (int j = 0; j < 32; j++) if (v[j]) p = j;
        for (int j = 0; j < 32; j++) m[j] = (p >= 0) && (excl ? (j < p) : (j <= p));
        push_exp(m[31:24], m[23:16], m[15:8], m[7:0], p >= 0, (p < 0) ? 5'd0 : 5'(p));
    endtask

    task automatic send_chunk(input logic [7:0] d, input logic e);
        bit r;
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_excl  = e;
        forever begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_ready stayed 0, required 1");
                break;
            end
        end
    endtask

    task automatic send_frame(input frame_t fr, input bit excl, input bit bubbles);
        for (int k = 0; k < 4; k++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(posedge clk);
                #1;
            end
            send_chunk(fr[k], (k == 0) ? excl : 1'($urandom));
        end
    endtask

    task automatic drain_check(input string name);
        int n = 0;
        int sz;
        s_valid = 1'b0;
        while (got_q.size() < exp_q.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d chunks, required %0d", name, got_q.size(), exp_q.size());
        end
        sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < sz; i++) begin
            checks++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].last !== exp_q[i].last ||
                (exp_q[i].last && (got_q[i].found !== exp_q[i].found || got_q[i].idx !== exp_q[i].idx))) begin
                errors++;
                $display("FAIL %s_chunk%0d: got data=%h last=%b found=%b idx=%0d, required data=%h last=%b found=%b idx=%0d",
                         name, i, got_q[i].d, got_q[i].last, got_q[i].found, got_q[i].idx,
                         exp_q[i].d, exp_q[i].last, exp_q[i].found, exp_q[i].idx);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 ||
            m_found !== 1'b0 || m_first_idx !== 5'd0) begin
            errors++;
            $display("FAIL %s: got s_ready=%b m_valid=%b m_data=%h m_last=%b m_found=%b idx=%0d, required all 0",
                     name, s_ready, m_valid, m_data, m_last, m_found, m_first_idx);
        end
    endtask

    task automatic reset_pulse(input string name);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(name);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        frame_t f;
        f = '{8'h00, 8'h00, 8'h10, 8'h00};
        push_exp(8'h00, 8'h00, 8'h1F, 8'hFF, 1'b1, 5'd12);
        send_frame(f, 1'b0, 1'b0);
        push_exp(8'h00, 8'h00, 8'h0F, 8'hFF, 1'b1, 5'd12);
        send_frame(f, 1'b1, 1'b0);
        f = '{8'h00, 8'h00, 8'h00, 8'h00};
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0);
        send_frame(f, 1'b0, 1'b0);
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0);
        send_frame(f, 1'b1, 1'b0);
        f = '{8'h80, 8'h01, 8'hFF, 8'h01};
        push_exp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 5'd31);
        send_frame(f, 1'b0, 1'b0);
        push_exp(8'h7F, 8'hFF, 8'hFF, 8'hFF, 1'b1, 5'd31);
        send_frame(f, 1'b1, 1'b0);
        drain_check("directed");
    endtask

    task automatic test_backpressure();
        push_exp(8'h00, 8'h00, 8'h1F, 8'hFF, 1'b1, 5'd12);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b0);
        s_data = 8'h10;
        @(negedge clk);
        force_ready = 1'b0;
        @(posedge clk);
        #1;
        s_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h1F) begin
                errors++;
                $display("FAIL stall_cycle%0d: got s_ready=%b m_valid=%b m_data=%h, required 0 1 1f",
                         i, s_ready, m_valid, m_data);
            end
            if (i == 2) force_ready = 1'b1;
        end
        send_chunk(8'h00, 1'b1);
        drain_check("backpressure");
    endtask

    task automatic test_reset_midframe();
        frame_t f;
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b0);
        reset_pulse("reset_after_2");
        f = '{8'h00, 8'h00, 8'h00, 8'h01};
        push_exp(8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 5'd0);
        send_frame(f, 1'b0, 1'b0);
        drain_check("post_reset_frame");
        send_chunk(8'h00, 1'b1);
        send_chunk(8'h00, 1'b1);
        send_chunk(8'h10, 1'b0);
        reset_pulse("reset_after_3");
        f = '{8'h00, 8'h02, 8'h00, 8'h00};
        push_exp(8'h00, 8'h03, 8'hFF, 8'hFF, 1'b1, 5'd17);
        send_frame(f, 1'b0, 1'b0);
        drain_check("post_reset_frame2");
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        push_exp(8'h3F, 8'hFF, 8'hFF, 8'hFF, 1'b1, 5'd30);
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 5'd0);
        t0 = $time;
        send_chunk(8'h40, 1'b1);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b1);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b1);
        send_chunk(8'h00, 1'b0);
        send_chunk(8'h00, 1'b1);
        t1 = $time;
        checks++;
        if (t1 - t0 != 80) begin
            errors++;
            $display("FAIL throughput: got %0t for 8 chunks, required 80", t1 - t0);
        end
        drain_check("back_to_back");
    endtask

    task automatic test_random();
        frame_t f;
        bit     e;
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: f[k] = 8'h00;
                    1: f[k] = 8'h01 << $urandom_range(0, 7);
                    default: f[k] = 8'($urandom);
                endcase
            end
            e = 1'($urandom);
            model_frame(f, e);
            send_frame(f, e, 1'b1);
        end
        rand_ready = 1'b0;
        drain_check("random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thermo_mask_stream.md
# thermo_mask_stream

Streaming, parametrised thermometer-mask generator. Takes a wide bit vector as a frame of `NUM_CHUNKS` chunks of `DATA_W` bits, MSB chunk first. For each chunk it emits a mask with every bit at and below the first (most-significant) one in the whole frame set; exclusive mode sets only the bits strictly below it. It carries the "one seen" state across chunks, reports the global index of the first one at frame end, and sits between the correlator peak-detect stage and the tracking-window gating logic.

## Interface
- `DATA_W`, 8, chunk width in bits (≥2)
- `NUM_CHUNKS`, 4, chunks per frame (≥1); full vector N = DATA_W*NUM_CHUNKS
- `IDX_W`, $clog2(DATA_W*NUM_CHUNKS), width of first_idx

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `s_valid`  in  1  input chunk valid
- `s_ready`  out  1  block can accept a chunk
- `s_data`  in  DATA_W  input chunk; bit DATA_W-1 is most significant
- `s_excl`  in  1  mode; 0 = inclusive, 1 = exclusive; sampled only on the first chunk of a frame
- `m_valid`  out  1  output chunk valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  DATA_W  mask chunk
- `m_last`  out  1  marks the final chunk of the frame
- `m_found`  out  1  a one was present in the frame; valid when m_valid & m_last
- `m_first_idx`  out  IDX_W  global bit index of the first one (N-1 = MSB of chunk 0); valid when m_valid & m_last

## Operation
- Transfer rule: a transfer occurs when valid and ready are both high on a rising edge. Input and output sides follow the same rule independently.
- Chunk counter `cnt` runs 0..NUM_CHUNKS-1. It advances on each input transfer and wraps to 0 after NUM_CHUNKS-1.
- On an input transfer with cnt==0:
  - clear `seen`
  - latch `s_excl` into `excl_q`
- Per-chunk kernel, with s = `seen` (after any clear when cnt==0):
  - inclusive: bit i = OR(s_data[DATA_W-1:i]) | s
  - exclusive: bit i = OR(s_data[DATA_W-1:i+1]) | s; bit DATA_W-1 = s
- Update: `seen` <= seen | (|s_data).
- First-one capture: on the first chunk in which a one appears (seen==0 and |s_data):
  - idx <= (NUM_CHUNKS-1-cnt)*DATA_W + position of the highest set bit
  - found <= 1
- At frame start, idx and found clear to 0, then update with the rule above.
- All-zero frame: every mask chunk is 0, m_found=0, m_first_idx=0, in both modes.
- m_last is high when the registered chunk had cnt==NUM_CHUNKS-1.
- NUM_CHUNKS==1: every chunk is both first and last.

## Timing
- Reset: all outputs 0 (s_ready=0 during reset, m_valid=0, m_data=0, m_last=0, m_found=0, m_first_idx=0). Internal cnt=0, seen=0, excl_q=0. After release, s_ready=1.
- Latency: one cycle, input transfer to m_valid.
- Throughput: one chunk per cycle when m_ready is held high.
- s_ready = !m_valid | m_ready. This is a single output register with combinational ready pass-through, so there is no skid buffer.
- Backpressure: while m_valid & !m_ready, m_data, m_last, m_found and m_first_idx are held stable, and no internal state advances.
- Input and output transfer in the same cycle: the register is replaced with the new chunk and m_valid stays 1.
- m_found and m_first_idx are registered with the last chunk and are only meaningful with m_last. Between frames they hold their last value.
- s_excl is ignored when cnt!=0, so mid-frame mode changes have no effect.
- Reset asserted mid-frame: immediate return to reset values. The next accepted chunk is treated as chunk 0, and the partial frame is discarded.
- Back-to-back frames: no idle cycle is required. `seen` clears on the first chunk of the new frame.

## Structure
- Shared package holds:
  - the default DATA_W and NUM_CHUNKS constants
  - a `thermo_mode_e` enum (INCL=0, EXCL=1)
- Sub-module `chunk_prefix_or` (parameter DATA_W; inputs chunk, carry_in, excl; outputs mask, any, hi_pos) is purely combinational and instantiated once.
- The top level holds:
  - the counter and `seen`/`excl_q` flags
  - idx/found capture
  - the output register and the handshake

## Test plan
- DATA_W=8, NUM_CHUNKS=4, inclusive, chunks 00,00,10,00 -> masks 00,00,1F,FF; m_last on the 4th chunk only; found=1, idx=12. Same frame in exclusive mode -> 00,00,0F,FF, idx=12.
- All-zero frame in both modes -> masks 00,00,00,00; found=0, idx=0.
- Chunks 80,01,FF,01, inclusive -> FF,FF,FF,FF, idx=31. Exclusive -> 7F,FF,FF,FF, idx=31.
- Backpressure: m_ready low for 3 cycles mid-frame with s_valid high -> s_ready low, m_data stable, no chunk lost or duplicated, final masks identical to the no-stall run.
- Reset asserted after 2 accepted chunks of 00,00,10,00 -> all outputs 0 within the reset. A following frame 00,00,00,01 yields masks 00,00,00,01, idx=0, found=1.
- Back-to-back frames: 40,00,00,00 (excl) then 00,00,00,00 (incl) with s_excl toggled mid-frame -> first frame 3F,FF,FF,FF, idx=30; second frame all 00, found=0; no carry leakage between frames.
